traffic_ctrl_multi: RTL and testbench

TRAFFIC_CTRL_MULTI -- requirements
Module: traffic_ctrl_multi

---
 rtl/traffic_ctrl_multi.sv | 154 +++++++++++++++
 tb/tb_traffic_ctrl_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic-light controller: round-robin green/yellow/all-red
// sequencing with a latched pedestrian walk phase and a flashing-yellow mode.
module traffic_ctrl_multi #(
  parameter int N_DIR     = 2,
  parameter int G_CYC     = 1000,
  parameter int Y_CYC     = 250,
  parameter int AR_CYC    = 100,
  parameter int PED_CYC   = 1000,
  parameter int FLASH_CYC = 500,
  parameter int CNT_W     = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped_btn_n,
  input  logic             flash_en,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yel,
  output logic [N_DIR-1:0] grn,
  output logic             walk,
  output logic             dont_walk,
  output logic             ped_pending,
  output logic [1:0]       active_dir
);

  typedef enum logic [2:0] {ALL_RED, GREEN, YELLOW, PED_WALK, FLASH} state_e;

  localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(G_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(AR_CYC - 1);
  localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(FLASH_CYC - 1);
  localparam logic [1:0]       DIR_LAST = 2'(N_DIR - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic             pend_q, pend_d;
  logic             phase_q, phase_d;
  logic [2:0]       ped_sync_q;
  logic [1:0]       flash_sync_q;
  logic             press;
  logic             flash_req;
  logic [N_DIR-1:0] dir_oh;

  // Stage 2 is the synchronised button; stage 3 only serves falling-edge detection.
  assign press     = ped_sync_q[2] & ~ped_sync_q[1];
  assign flash_req = flash_sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ALL_RED;
      cnt_q        <= '0;
      dir_q        <= '0;
      pend_q       <= 1'b0;
      phase_q      <= 1'b0;
      ped_sync_q   <= '0;
      flash_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      phase_q      <= phase_d;
      ped_sync_q   <= {ped_sync_q[1:0], ped_btn_n};
      flash_sync_q <= {flash_sync_q[0], flash_en};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    dir_d   = dir_q;
    phase_d = phase_q;
    case (state_q)
      ALL_RED: if (cnt_q == AR_LAST) begin
        cnt_d = '0;
        if (flash_req) begin
          state_d = FLASH;
          phase_d = 1'b0;
        end else if (pend_q) begin
          state_d = PED_WALK;
        end else begin
          state_d = GREEN;
        end
      end
      GREEN: if (cnt_q == G_LAST) begin
        state_d = YELLOW;
        cnt_d   = '0;
      end
      YELLOW: if (cnt_q == Y_LAST) begin
        state_d = ALL_RED;
        cnt_d   = '0;
        dir_d   = (dir_q == DIR_LAST) ? 2'd0 : dir_q + 2'd1;
      end
      PED_WALK: if (cnt_q == PED_LAST) begin
        state_d = GREEN;
        cnt_d   = '0;
      end
      FLASH: begin
        if (!flash_req) begin
          state_d = ALL_RED;
          cnt_d   = '0;
          dir_d   = '0;
        end else if (cnt_q == FL_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end
      end
      default: begin
        state_d = ALL_RED;
        cnt_d   = '0;
      end
    endcase

    // Clearing on walk entry wins over a press landing on the same edge.
    pend_d = pend_q;
    if ((state_d == PED_WALK && state_q != PED_WALK) || state_d == FLASH)
      pend_d = 1'b0;
    else if (press && state_q != PED_WALK && state_q != FLASH)
      pend_d = 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < N_DIR; i++)
      dir_oh[i] = (dir_q == 2'(i));
    red       = '1;
    yel       = '0;
    grn       = '0;
    walk      = 1'b0;
    dont_walk = 1'b1;
    case (state_q)
      GREEN: begin
        grn = dir_oh;
        red = ~dir_oh;
      end
      YELLOW: begin
        yel = dir_oh;
        red = ~dir_oh;
      end
      PED_WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      FLASH: begin
        red = '0;
        yel = phase_q ? '0 : '1;
      end
      default: ;
    endcase
    ped_pending = pend_q;
    active_dir  = dir_q;
  end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: a 3-approach instance against a countdown
// reference model, plus a 2-approach instance against a closed-form schedule.
module tb_traffic_ctrl_multi;

  localparam int N  = 3;
  localparam int G  = 8;
  localparam int Y  = 4;
  localparam int AR = 2;
  localparam int PW = 6;
  localparam int FL = 3;

  localparam int PH_AR = 0;
  localparam int PH_G  = 1;
  localparam int PH_Y  = 2;
  localparam int PH_W  = 3;
  localparam int PH_F  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ped_btn_n = 1'b1;
  logic flash_en = 1'b0;

  logic [2:0] red3, yel3, grn3;
  logic       walk3, dw3, pend3;
  logic [1:0] dir3;
  logic [1:0] red2, yel2, grn2;
  logic       walk2, dw2, pend2;
  logic [1:0] dir2;

  always #5 clk = ~clk;

  traffic_ctrl_multi #(
    .N_DIR(3), .G_CYC(G), .Y_CYC(Y), .AR_CYC(AR),
    .PED_CYC(PW), .FLASH_CYC(FL), .CNT_W(8)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .ped_btn_n(ped_btn_n), .flash_en(flash_en),
    .red(red3), .yel(yel3), .grn(grn3), .walk(walk3), .dont_walk(dw3),
    .ped_pending(pend3), .active_dir(dir3)
  );

  traffic_ctrl_multi #(
    .N_DIR(2), .G_CYC(G), .Y_CYC(Y), .AR_CYC(AR),
    .PED_CYC(PW), .FLASH_CYC(FL), .CNT_W(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ped_btn_n(1'b1), .flash_en(1'b0),
    .red(red2), .yel(yel2), .grn(grn2), .walk(walk2), .dont_walk(dw2),
    .ped_pending(pend2), .active_dir(dir2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: phase, cycles left in it, owner, pending flag, flash lamp state.
  int         m_ph = PH_AR;
  int         m_left = AR;
  int         m_dir = 0;
  bit         m_pend = 1'b0;
  bit         m_yon = 1'b1;
  logic [2:0] ped_h = '0;
  logic [1:0] fl_h = '0;
  int         t2 = 0;

  task automatic model_step();
    bit pressed, fl;
    int old;
    if (!rst_n) begin
      m_ph = PH_AR; m_left = AR; m_dir = 0; m_pend = 0; m_yon = 1;
      ped_h = '0; fl_h = '0; t2 = 0;
      return;
    end
    t2++;
    pressed = ped_h[2] && !ped_h[1];
    fl = fl_h[1];
    ped_h = {ped_h[1:0], ped_btn_n};
    fl_h = {fl_h[0], flash_en};
    old = m_ph;
    if (m_ph == PH_F) begin
      if (!fl) begin
        m_ph = PH_AR; m_left = AR; m_dir = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin m_yon = !m_yon; m_left = FL; end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        case (m_ph)
          PH_G: begin m_ph = PH_Y; m_left = Y; end
          PH_Y: begin m_ph = PH_AR; m_left = AR; m_dir = (m_dir + 1) % N; end
          PH_AR: begin
            if (fl) begin m_ph = PH_F; m_left = FL; m_yon = 1; end
            else if (m_pend) begin m_ph = PH_W; m_left = PW; end
            else begin m_ph = PH_G; m_left = G; end
          end
          default: begin m_ph = PH_G; m_left = G; end
        endcase
      end
    end
    if ((m_ph == PH_W && old != PH_W) || m_ph == PH_F) m_pend = 0;
    else if (pressed && old != PH_W && old != PH_F) m_pend = 1;
  endtask

  function automatic logic [13:0] exp3();
    logic [2:0] r, yl, g, oh;
    logic w, d;
    oh = 3'b001 << m_dir;
    r = 3'b111; yl = '0; g = '0; w = 0; d = 1;
    case (m_ph)
      PH_G: begin g = oh; r = ~oh; end
      PH_Y: begin yl = oh; r = ~oh; end
      PH_W: begin w = 1; d = 0; end
      PH_F: begin r = '0; yl = m_yon ? 3'b111 : 3'b000; end
      default: ;
    endcase
    return {r, yl, g, w, d, m_pend, 2'(m_dir)};
  endfunction

  function automatic logic [7:0] exp2();
    int m, d;
    logic [1:0] oh;
    if (t2 < AR) return {2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    m = (t2 - AR) % (G + Y + AR);
    d = ((t2 - AR) / (G + Y + AR)) % 2;
    oh = 2'b01 << d;
    if (m < G) return {~oh, 2'b00, oh, 1'b0, 1'b1};
    if (m < G + Y) return {~oh, oh, 2'b00, 1'b0, 1'b1};
    return {2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
  endfunction

  task automatic check(string tag, logic [13:0] obs, logic [13:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("n3_outputs", {red3, yel3, grn3, walk3, dw3, pend3, dir3}, exp3());
    check("n2_outputs", {6'b0, red2, yel2, grn2, walk2, dw2}, {6'b0, exp2()});
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_for(string tag, int ph, int dir);
    int k = 0;
    while (!(m_ph == ph && m_dir == dir) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) begin
      tests++;
      fails++;
      $error("FAIL %s observed=timeout expected=phase %0d dir %0d", tag, ph, dir);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    run(2);
    check("reset_lamps", {red3, yel3, grn3, walk3, dw3, pend3, dir3},
          {3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0});
    rst_n = 1'b1;

    // Idle sequence with full wrap.
    run(60);

    // Single-cycle press during green of approach 1.
    wait_for("wait_g1", PH_G, 1);
    ped_btn_n = 1'b0;
    tick();
    ped_btn_n = 1'b1;
    run(3);
    check("pend_after_pulse", {13'b0, pend3}, 14'd1);
    run(40);

    // Long hold, then a second press inside the walk phase.
    ped_btn_n = 1'b0;
    run(20);
    ped_btn_n = 1'b1;
    wait_for("wait_walk", PH_W, m_dir);
    run(2);
    ped_btn_n = 1'b0;
    tick();
    ped_btn_n = 1'b1;
    run(50);

    // Flash request during green of approach 0.
    wait_for("wait_g0", PH_G, 0);
    flash_en = 1'b1;
    run(50);
    flash_en = 1'b0;
    run(30);

    // Reset in the middle of yellow of approach 1 with a pending request.
    wait_for("wait_g1b", PH_G, 1);
    ped_btn_n = 1'b0;
    tick();
    ped_btn_n = 1'b1;
    wait_for("wait_y1", PH_Y, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("reset_mid_yellow", {red3, yel3, grn3, walk3, dw3, pend3, dir3},
          {3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0});
    rst_n = 1'b1;
    run(20);

    // Random buttons, flash toggles and occasional resets.
    for (int i = 0; i < 800; i++) begin
      ped_btn_n = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 79) == 0) flash_en = ~flash_en;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    flash_en = 1'b0;
    ped_btn_n = 1'b1;
    run(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
